seq_scan_arbiter: RTL
=====================

# seq_scan_arbiter

Shares one serial consecutive-ones scan engine between `N_REQ` bit-stream requesters. Grants are round-robin. For the granted requester, the block pulls exactly `req_len` bits over a valid/ready handshake. It counts runs of at least `RUN_MIN` consecutive ones and reports the result in a one-cycle done strobe. It sits between the serial sources and the result consumer and replaces per-source copies of the Moore sequence detector.

## Interface
- `N_REQ`, 4, number of requesters (2..8)
- `LEN_W`, 8, width of packet length and hit count
- `RUN_MIN`, 2, consecutive ones that constitute a hit (≥1)
- `clk` input 1: single clock; all state changes on rising edge
- `reset_n` input 1: asynchronous, active-low reset
- `req` input N_REQ: level request per requester; held until matching `done`
- `req_len` input N_REQ*LEN_W: packet length per requester, slice i = requester i
- `bit_valid` input N_REQ: source i presents a bit
- `bit_data` input N_REQ: bit value from source i
- `bit_ready` output N_REQ: one-hot (or zero) accept strobe to granted source
- `busy` output 1: state ≠ IDLE
- `gnt_id` output $clog2(N_REQ): current grantee, valid while busy
- `done` output 1: one-cycle result strobe
- `done_hit` output 1: count ≠ 0, valid with done
- `done_count` output LEN_W: number of qualifying runs, valid with done

## Operation
- States: IDLE, SCAN, REPORT.
  - IDLE: if any `req` is high, select the winner by round-robin search starting at `rr_ptr`.
  - On winning: latch `gnt_id`, latch `req_len[gnt]` into `remain`, clear `run` and `count`.
  - Then go to SCAN, or directly to REPORT if `req_len` = 0.
  - IDLE with no `req`: stay.
- SCAN: `bit_ready[gnt_id]`=1, all other bits 0. A bit is accepted when `bit_valid[gnt_id]` & ready.
- On each accepted bit:
  - 1: `run` = min(`run`+1, `RUN_MIN`); `count` += 1 when `run` goes from `RUN_MIN`-1 to `RUN_MIN`. A run of 7 ones with `RUN_MIN`=2 counts once.
  - 0: `run` = 0.
  - `remain` -= 1. The accepted bit with `remain`=1 moves to REPORT.
- No accept leaves SCAN unchanged. `bit_valid` from other sources is ignored.
- REPORT: `done`=1 for exactly one cycle with `done_hit`, `done_count`. `rr_ptr` = (`gnt_id`+1) mod `N_REQ`. Next state is IDLE.
- `req` is sampled only in IDLE. Deasserting `req` mid-transaction has no effect. The transaction completes only after `req_len` bits.
- `count` does not overflow: runs ≤ ceil(len/(`RUN_MIN`+1)) < 2^`LEN_W`.
- Reset values: state IDLE, `rr_ptr` 0, `bit_ready` 0, `busy` 0, `gnt_id` 0, `done` 0, `done_hit` 0, `done_count` 0, `run` 0, `remain` 0.
- Reset asserted mid-SCAN aborts immediately. No `done` is issued and the partial count is discarded.

## Timing
- Grant latency: `req` high in IDLE at cycle t → SCAN with `bit_ready` high at t+1. A zero-length request gives `done` at t+1.
- Throughput: one bit per cycle while `bit_valid` is held high.
- Last bit accepted at cycle k → `done` at k+1 → IDLE at k+2 → next SCAN at k+3 at the earliest.
- `done_*` are registered and held until the next REPORT. Consumers use them only with `done`.
- `bit_ready` is registered-state-derived (combinational from state and `gnt_id`). It has no combinational path from `bit_valid`.

## Structure
- Package `seq_scan_pkg`: state enum (IDLE, SCAN, REPORT), localparam `ID_W` = $clog2(`N_REQ`).
- Sub-module `rr_arbiter`: combinational round-robin winner.
  - Inputs: `req`, `rr_ptr`.
  - Outputs: `any`, `win_id`.
- The top holds the FSM, counters and output registers.

## Test plan
- Reset: hold `reset_n` low with `req`=4'b1111 → all outputs 0. After release, the first grant is `gnt_id`=0.
- Requester 1, len 6, bits 1,1,0,1,1,1 → `done` 7 cycles after grant, `done_count`=2, `done_hit`=1, `done` pulse one cycle wide.
- `req`=4'b1011 held continuously, each len 1 → grant order 0,1,3,0,1,3, spaced 3 cycles apart.
- Source 2, len 4, `bit_valid` toggling 1,0,1,0… with bits 0,1,1,0 → exactly 4 accepts, `bit_ready` only on bit 2, `done_count`=1. `RUN_MIN`=3 build with 1,1,0,1 → `done_count`=0, `done_hit`=0.
- `req_len`=0 on requester 3 → `done` at t+1, `done_count`=0, no `bit_ready` asserted.
- Assert `reset_n` low mid-SCAN after 3 of 8 bits → no `done`, `busy`=0, `rr_ptr`=0. After release, re-request runs the full 8 bits.

Source files
------------

// File: rtl/seq_scan_pkg.sv
// Shared types and width helpers for the shared consecutive-ones scan arbiter.
package seq_scan_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_REPORT
    } state_e;

    localparam int unsigned N_REQ_DEF = 4;

    // Requester id width; clamped to 1 so a degenerate count still yields a legal vector.
    function automatic int unsigned id_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned ID_W = id_width(N_REQ_DEF);

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin winner: first requester at or after rr_ptr, wrapping.
module rr_arbiter
    import seq_scan_pkg::*;
#(
    parameter int unsigned N  = N_REQ_DEF,
    parameter int unsigned IW = ID_W
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] rr_ptr,
    output logic          any,
    output logic [IW-1:0] win_id
);

    function automatic logic [IW-1:0] cand(input logic [IW-1:0] ptr, input int off);
        logic [31:0] s;
        s = 32'(ptr) + 32'(off);
        return IW'(s % 32'(N));
    endfunction

    // Walk offsets from farthest to nearest so the nearest pending request wins.
    always_comb begin
        any    = 1'b0;
        win_id = '0;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (req[cand(rr_ptr, i)]) begin
                any    = 1'b1;
                win_id = cand(rr_ptr, i);
            end
        end
    end

endmodule

// File: rtl/seq_scan_arbiter.sv
// One consecutive-ones run counter time-shared across N_REQ serial bit sources,
// granted round-robin, reporting each packet's run count with a one-cycle done strobe.
module seq_scan_arbiter
    import seq_scan_pkg::*;
#(
    parameter int unsigned N_REQ   = N_REQ_DEF,
    parameter int unsigned LEN_W   = 8,
    parameter int unsigned RUN_MIN = 2
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [N_REQ-1:0]           req,
    input  logic [N_REQ*LEN_W-1:0]     req_len,
    input  logic [N_REQ-1:0]           bit_valid,
    input  logic [N_REQ-1:0]           bit_data,
    output logic [N_REQ-1:0]           bit_ready,
    output logic                       busy,
    output logic [id_width(N_REQ)-1:0] gnt_id,
    output logic                       done,
    output logic                       done_hit,
    output logic [LEN_W-1:0]           done_count
);

    localparam int unsigned GW    = id_width(N_REQ);
    localparam int unsigned RUN_W = $clog2(RUN_MIN + 1);

    state_e            state, state_n;
    logic [GW-1:0]     rr_ptr, rr_ptr_n, gnt_n, win_id;
    logic              any;
    logic [LEN_W-1:0]  remain, remain_n, count, count_n;
    logic [RUN_W-1:0]  run, run_n;
    logic              accept;
    logic [LEN_W-1:0]  len_arr [N_REQ];

    for (genvar i = 0; i < int'(N_REQ); i++) begin : g_len
        assign len_arr[i] = req_len[i*LEN_W +: LEN_W];
    end

    rr_arbiter #(
        .N  (N_REQ),
        .IW (GW)
    ) u_rr (
        .req    (req),
        .rr_ptr (rr_ptr),
        .any    (any),
        .win_id (win_id)
    );

    assign accept = (state == ST_SCAN) && bit_valid[gnt_id] && bit_ready[gnt_id];

    // Next-state, grant capture and run/hit counting.
    always_comb begin
        state_n  = state;
        gnt_n    = gnt_id;
        rr_ptr_n = rr_ptr;
        remain_n = remain;
        run_n    = run;
        count_n  = count;
        case (state)
            ST_IDLE: begin
                if (any) begin
                    gnt_n    = win_id;
                    remain_n = len_arr[win_id];
                    run_n    = '0;
                    count_n  = '0;
                    state_n  = (len_arr[win_id] == '0) ? ST_REPORT : ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (accept) begin
                    remain_n = remain - LEN_W'(1);
                    if (bit_data[gnt_id]) begin
                        // Saturating run: a long run of ones is counted exactly once.
                        if (run == RUN_W'(RUN_MIN - 1)) begin
                            count_n = count + LEN_W'(1);
                        end
                        if (run != RUN_W'(RUN_MIN)) begin
                            run_n = run + RUN_W'(1);
                        end
                    end else begin
                        run_n = '0;
                    end
                    if (remain == LEN_W'(1)) begin
                        state_n = ST_REPORT;
                    end
                end
            end
            ST_REPORT: begin
                rr_ptr_n = (gnt_id == GW'(N_REQ - 1)) ? '0 : gnt_id + GW'(1);
                state_n  = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // State, counters and registered outputs derived from the next state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            rr_ptr     <= '0;
            gnt_id     <= '0;
            remain     <= '0;
            run        <= '0;
            count      <= '0;
            bit_ready  <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            done_hit   <= 1'b0;
            done_count <= '0;
        end else begin
            state     <= state_n;
            rr_ptr    <= rr_ptr_n;
            gnt_id    <= gnt_n;
            remain    <= remain_n;
            run       <= run_n;
            count     <= count_n;
            bit_ready <= (state_n == ST_SCAN) ? (N_REQ'(1) << gnt_n) : '0;
            busy      <= (state_n != ST_IDLE);
            done      <= (state_n == ST_REPORT);
            if (state_n == ST_REPORT) begin
                done_count <= count_n;
                done_hit   <= (count_n != '0);
            end
        end
    end

endmodule
